// File: rtl/fetch_stage.sv
// fetch_stage: RV32I PC register, single-outstanding imem request FSM, and IF/ID register.
// Define FETCH_PERF_EN to add fetch_bubble_cnt, which counts cycles where Decode starves.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_bubble_cnt
`endif
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} FetchState;

    FetchState   state;
    logic [31:0] pcInflight;
    logic [31:0] bufInstr;
    logic [31:0] bufPc;
    logic        reqFire;
    logic        loadD;
    logic [31:0] loadInstr;
    logic [31:0] loadPc;

    assign imem_req_valid = (state == REQ) && !StallF && !PCSrcE && !reset;
    assign imem_req_addr  = PCF;
    assign reqFire        = imem_req_valid && imem_req_ready;

    // Decode is fed directly from memory or from the stall buffer; a redirect kills either source.
    always_comb begin
        loadD     = 1'b0;
        loadInstr = imem_rsp_data;
        loadPc    = pcInflight;
        if (!PCSrcE) begin
            if (state == WAIT && imem_rsp_valid && !StallD) begin
                loadD = 1'b1;
            end else if (state == HOLD && !StallD) begin
                loadD     = 1'b1;
                loadInstr = bufInstr;
                loadPc    = bufPc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            PCF        <= RESET_PC;
            pcInflight <= '0;
            bufInstr   <= NOP_INSTR;
            bufPc      <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (PCSrcE) begin
                        PCF <= PCTargetE;
                    end else if (reqFire) begin
                        pcInflight <= PCF;
                        PCF        <= PCF + 32'd4;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (PCSrcE) begin
                        PCF   <= PCTargetE;
                        state <= imem_rsp_valid ? REQ : DRAIN;
                    end else if (imem_rsp_valid) begin
                        if (StallD) begin
                            bufInstr <= imem_rsp_data;
                            bufPc    <= pcInflight;
                            state    <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        PCF   <= PCTargetE;
                        state <= REQ;
                    end else if (!StallD) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    // The outstanding response belongs to the abandoned path, so it only ends the drain.
                    if (PCSrcE) begin
                        PCF <= PCTargetE;
                    end
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (loadD) begin
                InstrD   <= loadInstr;
                PCD      <= loadPc;
                PCPlus4D <= loadPc + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_bubble_cnt <= '0;
        end else if (!FlushD && !StallD && !loadD) begin
            fetch_bubble_cnt <= fetch_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: lockstep memory model plus scoreboard of expected Decode contents for fetch_stage.
// Build with FETCH_PERF_EN to also check fetch_bubble_cnt.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ExpEntry;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_bubble_cnt;
`endif

    ExpEntry     expQ[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    int          memLatency = 1;
    bit          pending = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = '0;
    logic [31:0] modelPc = RESET_PC;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
        , .fetch_bubble_cnt(fetch_bubble_cnt)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h100) return 32'h0050_0093;
        return {addr[11:0], 20'h00093};
    endfunction

    // One clock: memory accepts on the edge, then answers memLatency cycles later at the address actually presented.
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        ExpEntry     e;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pending  = 1'b1;
            pendCnt  = memLatency;
            pendAddr = a;
            e.pc     = modelPc;
            e.instr  = memWord(modelPc);
            expQ.push_back(e);
            modelPc  = modelPc + 32'd4;
        end
        if (pending) begin
            if (pendCnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pendAddr);
                pending        = 1'b0;
            end else begin
                pendCnt--;
            end
        end
    endtask

    task automatic popExp(output logic [31:0] pc, output logic [31:0] instr, output bit ok);
        ExpEntry e;
        ok    = (expQ.size() != 0);
        pc    = 'x;
        instr = 'x;
        if (ok) begin
            e     = expQ.pop_front();
            pc    = e.pc;
            instr = e.instr;
        end
    endtask

    task automatic dropExp();
        if (expQ.size() != 0) void'(expQ.pop_front());
    endtask

    task automatic doReset();
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        memLatency = 1; pending = 1'b0; modelPc = RESET_PC; expQ.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        doReset();
        #1;
        nCompared++; if (PCF !== RESET_PC) begin nMismatched++; $display("[TB] FAIL reset_pcf: got %h expected %h", PCF, RESET_PC); end
        nCompared++; if (InstrD !== NOP) begin nMismatched++; $display("[TB] FAIL reset_instrd: got %h expected %h", InstrD, NOP); end
        nCompared++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pcd: got %h/%h expected 0/0", PCD, PCPlus4D); end
        nCompared++; if (ValidD !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_validd: got %b expected 0", ValidD); end
        nCompared++; if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_reqvalid: got %b expected 0", imem_req_valid); end
`ifdef FETCH_PERF_EN
        nCompared++; if (fetch_bubble_cnt !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_bubblecnt: got %0d expected 0", fetch_bubble_cnt); end
`endif
        reset = 1'b0;
        #1;
        nCompared++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin nMismatched++; $display("[TB] FAIL reset_first_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
    endtask

    task automatic test_basic();
        logic [31:0] ePc, eInstr;
        bit          ok;
        tick();
        #1;
        nCompared++; if (PCF !== modelPc) begin nMismatched++; $display("[TB] FAIL basic_pcf_advance: got %h expected %h", PCF, modelPc); end
        nCompared++; if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_one_outstanding: got %b expected 0", imem_req_valid); end
        tick();
        #1;
        popExp(ePc, eInstr, ok);
        nCompared++; if (!ok || InstrD !== eInstr || InstrD !== 32'h0050_0093) begin nMismatched++; $display("[TB] FAIL basic_instrd: got %h expected %h", InstrD, eInstr); end
        nCompared++; if (PCD !== ePc || PCPlus4D !== ePc + 32'd4) begin nMismatched++; $display("[TB] FAIL basic_pcd: got %h/%h expected %h/%h", PCD, PCPlus4D, ePc, ePc + 32'd4); end
        nCompared++; if (ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_validd: got %b expected 1", ValidD); end
        nCompared++; if (imem_req_valid !== 1'b1 || imem_req_addr !== modelPc) begin nMismatched++; $display("[TB] FAIL basic_next_addr: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, modelPc); end
    endtask

    task automatic test_ready_stall();
        logic [31:0] ePc, eInstr;
        bit          ok;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++; if (imem_req_valid !== 1'b1 || imem_req_addr !== modelPc || PCF !== modelPc) begin nMismatched++; $display("[TB] FAIL ready_low_stable: got %b/%h/%h expected 1/%h/%h", imem_req_valid, imem_req_addr, PCF, modelPc, modelPc); end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        #1;
        nCompared++; if (PCF !== modelPc) begin nMismatched++; $display("[TB] FAIL ready_accept_pcf: got %h expected %h", PCF, modelPc); end
        tick();
        #1;
        popExp(ePc, eInstr, ok);
        nCompared++; if (!ok || InstrD !== eInstr || PCD !== ePc || ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL ready_load: got %h/%h/%b expected %h/%h/1", InstrD, PCD, ValidD, eInstr, ePc); end
    endtask

    task automatic test_stall_hold();
        logic [31:0] ePc, eInstr;
        bit          ok;
        tick();
        StallD = 1'b1;
        tick();
        imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        nCompared++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h104) begin nMismatched++; $display("[TB] FAIL hold_d_frozen: got %h/%b/%h expected %h/0/104", InstrD, ValidD, PCD, NOP); end
        nCompared++; if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_no_req: got %b expected 0", imem_req_valid); end
        tick();
        #1;
        nCompared++; if (InstrD !== NOP || ValidD !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_d_frozen2: got %h/%b expected %h/0", InstrD, ValidD, NOP); end
        StallD = 1'b0;
        tick();
        #1;
        popExp(ePc, eInstr, ok);
        nCompared++; if (!ok || InstrD !== eInstr || PCD !== ePc || PCPlus4D !== ePc + 32'd4 || ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_release_load: got %h/%h/%h/%b expected %h/%h/%h/1", InstrD, PCD, PCPlus4D, ValidD, eInstr, ePc, ePc + 32'd4); end
        nCompared++; if (imem_req_valid !== 1'b1 || imem_req_addr !== modelPc) begin nMismatched++; $display("[TB] FAIL hold_next_addr: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, modelPc); end
    endtask

    task automatic test_redirect_drain();
        memLatency = 3;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h200; modelPc = 32'h200;
        #1;
        nCompared++; if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_redirect_noreq: got %b expected 0", imem_req_valid); end
        tick();
        PCSrcE = 1'b0;
        dropExp();
        #1;
        nCompared++; if (PCF !== 32'h200 || imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_enter: got %h/%b expected 200/0", PCF, imem_req_valid); end
        tick();
        #1;
        nCompared++; if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_waiting: got %b expected 0", imem_req_valid); end
        tick();
        #1;
        nCompared++; if (ValidD !== 1'b0 || InstrD !== NOP) begin nMismatched++; $display("[TB] FAIL drain_discard: got %h/%b expected %h/0", InstrD, ValidD, NOP); end
        nCompared++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin nMismatched++; $display("[TB] FAIL drain_target_addr: got %b/%h expected 1/200", imem_req_valid, imem_req_addr); end
        memLatency = 1;
    endtask

    task automatic test_hold_flush();
        logic [31:0] ePc, eInstr;
        bit          ok;
        tick();
        StallD = 1'b1;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h300; FlushD = 1'b1; modelPc = 32'h300;
        tick();
        PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
        dropExp();
        #1;
        nCompared++; if (InstrD !== NOP || ValidD !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_bubble: got %h/%b expected %h/0", InstrD, ValidD, NOP); end
        nCompared++; if (PCF !== 32'h300 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin nMismatched++; $display("[TB] FAIL flush_target: got %h/%b/%h expected 300/1/300", PCF, imem_req_valid, imem_req_addr); end
        tick();
        tick();
        #1;
        popExp(ePc, eInstr, ok);
        nCompared++; if (!ok || InstrD !== eInstr || PCD !== ePc || ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_refetch: got %h/%h/%b expected %h/%h/1", InstrD, PCD, ValidD, eInstr, ePc); end
    endtask

    task automatic test_wait_redirect_rsp();
        logic [31:0] ePc, eInstr;
        bit          ok;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h400; modelPc = 32'h400;
        tick();
        PCSrcE = 1'b0;
        dropExp();
        #1;
        nCompared++; if (ValidD !== 1'b0 || InstrD !== NOP) begin nMismatched++; $display("[TB] FAIL waitredir_discard: got %h/%b expected %h/0", InstrD, ValidD, NOP); end
        nCompared++; if (PCF !== 32'h400 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin nMismatched++; $display("[TB] FAIL waitredir_target: got %h/%b/%h expected 400/1/400", PCF, imem_req_valid, imem_req_addr); end
        tick();
        tick();
        #1;
        popExp(ePc, eInstr, ok);
        nCompared++; if (!ok || InstrD !== eInstr || PCD !== ePc || ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL waitredir_refetch: got %h/%h/%b expected %h/%h/1", InstrD, PCD, ValidD, eInstr, ePc); end
    endtask

    task automatic test_reset_midflight();
        memLatency = 2;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_req_ready = 1'b0;
        expQ.delete();
        modelPc = RESET_PC;
        #1;
        nCompared++; if (PCF !== RESET_PC || ValidD !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_state: got %h/%b expected %h/0", PCF, ValidD, RESET_PC); end
        tick();
        #1;
        nCompared++; if (ValidD !== 1'b0 || InstrD !== NOP || PCF !== RESET_PC) begin nMismatched++; $display("[TB] FAIL midreset_stale_ignored: got %h/%b/%h expected %h/0/%h", InstrD, ValidD, PCF, NOP, RESET_PC); end
        imem_req_ready = 1'b1;
        memLatency = 1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ePc, eInstr;
        bit          ok;
        bit          hadRsp;
        int          loads = 0;
        int          bubbleExp = 0;
        doReset();
        reset = 1'b0;
        memLatency = 3;
        for (int cyc = 0; cyc < 80 && loads < 4; cyc++) begin
            hadRsp = imem_rsp_valid;
            FlushD = !hadRsp && (cyc == 2);
            StallD = !hadRsp && (cyc == 5 || cyc == 6);
            if (!hadRsp && !FlushD && !StallD) bubbleExp++;
            tick();
            if (hadRsp) begin
                #1;
                popExp(ePc, eInstr, ok);
                nCompared++; if (!ok || InstrD !== eInstr || PCD !== ePc || PCPlus4D !== ePc + 32'd4 || ValidD !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_load: got %h/%h/%h/%b expected %h/%h/%h/1", InstrD, PCD, PCPlus4D, ValidD, eInstr, ePc, ePc + 32'd4); end
                loads++;
            end
        end
        FlushD = 1'b0;
        StallD = 1'b0;
        nCompared++; if (loads != 4) begin nMismatched++; $display("[TB] FAIL b2b_timeout: got %0d loads expected 4", loads); end
`ifdef FETCH_PERF_EN
        nCompared++; if (fetch_bubble_cnt !== 32'(bubbleExp)) begin nMismatched++; $display("[TB] FAIL perf_bubble_cnt: got %0d expected %0d", fetch_bubble_cnt, bubbleExp); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_stall();
        test_stall_hold();
        test_redirect_drain();
        test_hold_flush();
        test_wait_redirect_rsp();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
